ttc_apb_regif_lite5: RTL and testbench

- APB3 slave front-end for one lite timer/counter channel.
- Decodes APB transfers into the channel's one-cycle register-select strobes, a registered 16-bit write bus and a clear-interrupt pulse.
- Muxes channel register values back onto prdata5.
- Sits between the APB bridge and the timer channel; it is the initiator end of the channel's select/pwdata/clear interface.

---
 rtl/ttc_regif_pkg5.sv | 54 +++++
 rtl/ttc_apb_regif_lite5.sv | 178 +++++++++++++++++
 tb/tb_ttc_apb_regif_lite5.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ttc_regif_pkg5.sv
// Shared definitions for the lite timer/counter APB register interface:
// register offsets, FSM state encoding and address classification helpers.
package ttc_regif_pkg5;

  // Byte offsets of the channel registers (only paddr[6:0] is decoded)
  localparam logic [6:0] OFF_CLK_CTRL5    = 7'h00;
  localparam logic [6:0] OFF_CNTR_CTRL5   = 7'h0C;
  localparam logic [6:0] OFF_COUNTER_VAL5 = 7'h18;
  localparam logic [6:0] OFF_INTERVAL5    = 7'h24;
  localparam logic [6:0] OFF_MATCH_15     = 7'h30;
  localparam logic [6:0] OFF_MATCH_25     = 7'h3C;
  localparam logic [6:0] OFF_MATCH_35     = 7'h48;
  localparam logic [6:0] OFF_INTR_STAT5   = 7'h54;
  localparam logic [6:0] OFF_INTR_EN5     = 7'h60;

  // Writable registers; index gi drives write strobe gi
  // (0 clk_ctrl, 1 cntr_ctrl, 2 interval, 3..5 match1..3, 6 intr_en)
  localparam int NUM_WR5 = 7;
  localparam logic [NUM_WR5-1:0][6:0] WR_OFFSETS5 = {
    OFF_INTR_EN5, OFF_MATCH_35, OFF_MATCH_25, OFF_MATCH_15,
    OFF_INTERVAL5, OFF_CNTR_CTRL5, OFF_CLK_CTRL5
  };

  // Read-only registers; a write to any of these is an error
  localparam int NUM_RO5 = 2;
  localparam logic [NUM_RO5-1:0][6:0] RO_OFFSETS5 = {
    OFF_INTR_STAT5, OFF_COUNTER_VAL5
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RD_ACK = 2'd2
  } regif_state_t;

  function automatic logic is_ro5(input logic [6:0] off);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_RO5; i++) begin
      if (off == RO_OFFSETS5[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_mapped5(input logic [6:0] off);
    logic hit;
    hit = is_ro5(off);
    for (int i = 0; i < NUM_WR5; i++) begin
      if (off == WR_OFFSETS5[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ttc_apb_regif_lite5.sv
// APB3 slave front-end for one lite timer/counter channel. Writes complete
// with no wait state and produce a one-cycle select strobe plus registered
// write data; reads take one wait state and return a value captured in the
// first access cycle. Reading interrupt status pulses clear_interrupt5.
module ttc_apb_regif_lite5
  import ttc_regif_pkg5::*;
#(
  parameter int APB_AW5 = 8
) (
  input  logic               pclk5,
  input  logic               n_p_reset5,
  input  logic               psel5,
  input  logic               penable5,
  input  logic               pwrite5,
  input  logic [APB_AW5-1:0] paddr5,
  input  logic [31:0]        pwdata5,
  output logic [31:0]        prdata5,
  output logic               pready5,
  output logic               pslverr5,
  output logic [15:0]        wdata_out5,
  output logic               clk_ctrl_reg_sel5,
  output logic               cntr_ctrl_reg_sel5,
  output logic               interval_reg_sel5,
  output logic               match_1_reg_sel5,
  output logic               match_2_reg_sel5,
  output logic               match_3_reg_sel5,
  output logic               intr_en_reg_sel5,
  output logic               clear_interrupt5,
  input  logic [6:0]         clk_ctrl_reg5,
  input  logic [6:0]         cntr_ctrl_reg5,
  input  logic [15:0]        counter_val_reg5,
  input  logic [15:0]        interval_reg5,
  input  logic [15:0]        match_1_reg5,
  input  logic [15:0]        match_2_reg5,
  input  logic [15:0]        match_3_reg5,
  input  logic [5:0]         interrupt_reg5,
  input  logic [5:0]         interrupt_en_reg5
);

  regif_state_t         state_reg, state_next;
  logic [6:0]           addr_reg;
  logic                 write_reg;
  logic [15:0]          wdata_reg;
  logic                 err_reg;
  logic [31:0]          prdata_reg;
  logic [15:0]          wdata_out_reg;
  logic [NUM_WR5-1:0]   sel_reg;
  logic                 clr_reg;

  logic                 setup;
  logic                 enabled;
  logic                 setup_err;
  logic                 wr_fire;
  logic                 rd_capture;
  logic [31:0]          rd_mux;
  logic [NUM_WR5-1:0]   sel_dec;

  assign setup   = psel5 & ~penable5;
  assign enabled = psel5 & penable5;

  // Classify the setup-phase address; upper bits and byte lanes must be zero
  always_comb begin
    setup_err = 1'b0;
    if ((paddr5 >> 7) != '0)               setup_err = 1'b1;
    if (paddr5[1:0] != 2'b00)              setup_err = 1'b1;
    if (!is_mapped5(paddr5[6:0]))          setup_err = 1'b1;
    if (pwrite5 && is_ro5(paddr5[6:0]))    setup_err = 1'b1;
  end

  assign wr_fire    = (state_reg == ACCESS) & enabled & write_reg & ~err_reg;
  assign rd_capture = (state_reg == ACCESS) & enabled & ~write_reg & ~err_reg;

  // One-hot decode of the latched address into write strobes
  generate
    for (genvar gi = 0; gi < NUM_WR5; gi++) begin : g_sel_dec
      assign sel_dec[gi] = (addr_reg == WR_OFFSETS5[gi]);
    end
  endgenerate

  // Read mux: narrow channel registers are zero-extended
  always_comb begin
    rd_mux = 32'h0;
    case (addr_reg)
      OFF_CLK_CTRL5:    rd_mux = {25'h0, clk_ctrl_reg5};
      OFF_CNTR_CTRL5:   rd_mux = {25'h0, cntr_ctrl_reg5};
      OFF_COUNTER_VAL5: rd_mux = {16'h0, counter_val_reg5};
      OFF_INTERVAL5:    rd_mux = {16'h0, interval_reg5};
      OFF_MATCH_15:     rd_mux = {16'h0, match_1_reg5};
      OFF_MATCH_25:     rd_mux = {16'h0, match_2_reg5};
      OFF_MATCH_35:     rd_mux = {16'h0, match_3_reg5};
      OFF_INTR_STAT5:   rd_mux = {26'h0, interrupt_reg5};
      OFF_INTR_EN5:     rd_mux = {26'h0, interrupt_en_reg5};
      default:          rd_mux = 32'h0;
    endcase
  end

  // FSM state register
  always_ff @(posedge pclk5 or negedge n_p_reset5) begin
    if (!n_p_reset5) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  // FSM next state; ACCESS without an enabled transfer aborts silently
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (setup) state_next = ACCESS;
      ACCESS: begin
        if (!enabled)                state_next = IDLE;
        else if (write_reg || err_reg) state_next = IDLE;
        else                         state_next = RD_ACK;
      end
      RD_ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; read data is only driven while an error-free read completes
  always_comb begin
    pready5  = 1'b0;
    pslverr5 = 1'b0;
    prdata5  = 32'h0;
    case (state_reg)
      ACCESS: begin
        pready5  = enabled & (write_reg | err_reg);
        pslverr5 = enabled & err_reg;
      end
      RD_ACK: begin
        pready5 = 1'b1;
        prdata5 = prdata_reg;
      end
      default: ;
    endcase
  end

  // Transfer context latched at setup, read value captured in ACCESS
  always_ff @(posedge pclk5 or negedge n_p_reset5) begin
    if (!n_p_reset5) begin
      addr_reg   <= 7'h0;
      write_reg  <= 1'b0;
      wdata_reg  <= 16'h0;
      err_reg    <= 1'b0;
      prdata_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && setup) begin
        addr_reg  <= paddr5[6:0];
        write_reg <= pwrite5;
        wdata_reg <= pwdata5[15:0];
        err_reg   <= setup_err;
      end
      if (rd_capture) prdata_reg <= rd_mux;
    end
  end

  // Channel-side outputs: strobes and clear pulse last exactly one cycle
  always_ff @(posedge pclk5 or negedge n_p_reset5) begin
    if (!n_p_reset5) begin
      wdata_out_reg <= 16'h0;
      sel_reg       <= '0;
      clr_reg       <= 1'b0;
    end else begin
      sel_reg <= wr_fire ? sel_dec : '0;
      if (wr_fire) wdata_out_reg <= wdata_reg;
      clr_reg <= (state_reg == RD_ACK) && (addr_reg == OFF_INTR_STAT5);
    end
  end

  assign wdata_out5         = wdata_out_reg;
  assign clk_ctrl_reg_sel5  = sel_reg[0];
  assign cntr_ctrl_reg_sel5 = sel_reg[1];
  assign interval_reg_sel5  = sel_reg[2];
  assign match_1_reg_sel5   = sel_reg[3];
  assign match_2_reg_sel5   = sel_reg[4];
  assign match_3_reg_sel5   = sel_reg[5];
  assign intr_en_reg_sel5   = sel_reg[6];
  assign clear_interrupt5   = clr_reg;

endmodule

// File: tb/tb_ttc_apb_regif_lite5.sv
// Directed bench for the lite timer APB register interface.
module tb_ttc_apb_regif_lite5;

  logic        pclk5 = 1'b0;
  logic        n_p_reset5;
  logic        psel5, penable5, pwrite5;
  logic [7:0]  paddr5;
  logic [31:0] pwdata5;
  logic [31:0] prdata5;
  logic        pready5, pslverr5;
  logic [15:0] wdata_out5;
  logic        clk_ctrl_reg_sel5, cntr_ctrl_reg_sel5, interval_reg_sel5;
  logic        match_1_reg_sel5, match_2_reg_sel5, match_3_reg_sel5;
  logic        intr_en_reg_sel5, clear_interrupt5;
  logic [6:0]  clk_ctrl_reg5, cntr_ctrl_reg5;
  logic [15:0] counter_val_reg5, interval_reg5;
  logic [15:0] match_1_reg5, match_2_reg5, match_3_reg5;
  logic [5:0]  interrupt_reg5, interrupt_en_reg5;

  int checks = 0;
  int errors = 0;

  // {clk_ctrl, cntr_ctrl, interval, match1, match2, match3, intr_en}
  logic [6:0] sels;
  assign sels = {clk_ctrl_reg_sel5, cntr_ctrl_reg_sel5, interval_reg_sel5,
                 match_1_reg_sel5, match_2_reg_sel5, match_3_reg_sel5,
                 intr_en_reg_sel5};

  localparam logic [6:0] S_NONE     = 7'b0000000;
  localparam logic [6:0] S_INTERVAL = 7'b0010000;
  localparam logic [6:0] S_MATCH1   = 7'b0001000;
  localparam logic [6:0] S_MATCH2   = 7'b0000100;
  localparam logic [6:0] S_INTR_EN  = 7'b0000001;

  always #5 pclk5 = ~pclk5;

  ttc_apb_regif_lite5 #(.APB_AW5(8)) dut (
    .pclk5(pclk5), .n_p_reset5(n_p_reset5),
    .psel5(psel5), .penable5(penable5), .pwrite5(pwrite5),
    .paddr5(paddr5), .pwdata5(pwdata5),
    .prdata5(prdata5), .pready5(pready5), .pslverr5(pslverr5),
    .wdata_out5(wdata_out5),
    .clk_ctrl_reg_sel5(clk_ctrl_reg_sel5), .cntr_ctrl_reg_sel5(cntr_ctrl_reg_sel5),
    .interval_reg_sel5(interval_reg_sel5), .match_1_reg_sel5(match_1_reg_sel5),
    .match_2_reg_sel5(match_2_reg_sel5), .match_3_reg_sel5(match_3_reg_sel5),
    .intr_en_reg_sel5(intr_en_reg_sel5), .clear_interrupt5(clear_interrupt5),
    .clk_ctrl_reg5(clk_ctrl_reg5), .cntr_ctrl_reg5(cntr_ctrl_reg5),
    .counter_val_reg5(counter_val_reg5), .interval_reg5(interval_reg5),
    .match_1_reg5(match_1_reg5), .match_2_reg5(match_2_reg5),
    .match_3_reg5(match_3_reg5), .interrupt_reg5(interrupt_reg5),
    .interrupt_en_reg5(interrupt_en_reg5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [7:0] a, input logic w, input logic [31:0] d);
    @(posedge pclk5); #1;
    psel5 = 1'b1; penable5 = 1'b0; paddr5 = a; pwrite5 = w; pwdata5 = d;
  endtask

  task automatic access();
    @(posedge pclk5); #1;
    penable5 = 1'b1;
  endtask

  task automatic hold();
    @(posedge pclk5); #1;
  endtask

  task automatic idle();
    @(posedge pclk5); #1;
    psel5 = 1'b0; penable5 = 1'b0;
  endtask

  // Error transfer: completes in the first access cycle with pslverr, no side effects
  task automatic err_xfer(input string tag, input logic [7:0] a, input logic w,
                          input logic [15:0] wd_keep);
    setup(a, w, 32'h0000_AAAA);
    access();
    @(negedge pclk5);
    chk({tag, "_pready"},  {31'h0, pready5},  32'h1);
    chk({tag, "_pslverr"}, {31'h0, pslverr5}, 32'h1);
    chk({tag, "_prdata"},  prdata5,           32'h0);
    idle();
    @(negedge pclk5);
    chk({tag, "_sel"},   {25'h0, sels},             {25'h0, S_NONE});
    chk({tag, "_clr"},   {31'h0, clear_interrupt5}, 32'h0);
    chk({tag, "_wdata"}, {16'h0, wdata_out5},       {16'h0, wd_keep});
    $display("xfer %s addr=%h write=%0d -> error response", tag, a, w);
  endtask

  initial begin
    n_p_reset5 = 1'b0;
    psel5 = 1'b1; penable5 = 1'b0; pwrite5 = 1'b1; paddr5 = 8'h24; pwdata5 = 32'hFFFF;
    clk_ctrl_reg5 = 7'h11; cntr_ctrl_reg5 = 7'h22;
    counter_val_reg5 = 16'hBEEF; interval_reg5 = 16'h0101;
    match_1_reg5 = 16'h5A5A; match_2_reg5 = 16'hA5A5; match_3_reg5 = 16'h3333;
    interrupt_reg5 = 6'b100101; interrupt_en_reg5 = 6'h3F;

    // Reset held with psel high: everything quiet
    repeat (3) @(posedge pclk5);
    @(negedge pclk5);
    chk("rst_pready",  {31'h0, pready5},  32'h0);
    chk("rst_pslverr", {31'h0, pslverr5}, 32'h0);
    chk("rst_prdata",  prdata5,           32'h0);
    chk("rst_sel",     {25'h0, sels},     32'h0);
    chk("rst_wdata",   {16'h0, wdata_out5}, 32'h0);
    chk("rst_clr",     {31'h0, clear_interrupt5}, 32'h0);
    $display("reset held: outputs quiet");
    #1 psel5 = 1'b0;
    n_p_reset5 = 1'b1;

    // Write 0x1234 to interval
    setup(8'h24, 1'b1, 32'h0000_1234);
    access();
    @(negedge pclk5);
    chk("wr24_pready",  {31'h0, pready5},  32'h1);
    chk("wr24_pslverr", {31'h0, pslverr5}, 32'h0);
    chk("wr24_sel_early", {25'h0, sels},   {25'h0, S_NONE});
    idle();
    @(negedge pclk5);
    chk("wr24_sel",   {25'h0, sels},       {25'h0, S_INTERVAL});
    chk("wr24_wdata", {16'h0, wdata_out5}, 32'h1234);
    hold();
    @(negedge pclk5);
    chk("wr24_sel_off", {25'h0, sels},       {25'h0, S_NONE});
    chk("wr24_hold",    {16'h0, wdata_out5}, 32'h1234);
    $display("xfer write addr=24 data=1234");

    // Read counter_val: one wait state
    setup(8'h18, 1'b0, 32'h0);
    access();
    @(negedge pclk5);
    chk("rd18_wait_pready", {31'h0, pready5}, 32'h0);
    chk("rd18_wait_prdata", prdata5,          32'h0);
    hold();
    @(negedge pclk5);
    chk("rd18_pready",  {31'h0, pready5},  32'h1);
    chk("rd18_pslverr", {31'h0, pslverr5}, 32'h0);
    chk("rd18_prdata",  prdata5,           32'h0000_BEEF);
    idle();
    @(negedge pclk5);
    chk("rd18_clr",    {31'h0, clear_interrupt5}, 32'h0);
    chk("rd18_after",  prdata5,                   32'h0);
    $display("xfer read addr=18 data=%h", 32'h0000_BEEF);

    // Read interrupt status; value changes during RD_ACK must not show
    setup(8'h54, 1'b0, 32'h0);
    access();
    @(negedge pclk5);
    chk("rd54_wait_pready", {31'h0, pready5}, 32'h0);
    hold();
    interrupt_reg5 = 6'b000000;
    @(negedge pclk5);
    chk("rd54_prdata",  prdata5,                   32'h25);
    chk("rd54_clr_early", {31'h0, clear_interrupt5}, 32'h0);
    idle();
    @(negedge pclk5);
    chk("rd54_clr",     {31'h0, clear_interrupt5}, 32'h1);
    hold();
    @(negedge pclk5);
    chk("rd54_clr_off", {31'h0, clear_interrupt5}, 32'h0);
    $display("xfer read addr=54 data=25 clear pulsed");

    // Error cases
    err_xfer("wr18_ro",  8'h18, 1'b1, 16'h1234);
    err_xfer("rd70_map", 8'h70, 1'b0, 16'h1234);
    err_xfer("rd26_algn", 8'h26, 1'b0, 16'h1234);
    err_xfer("wr26_algn", 8'h26, 1'b1, 16'h1234);
    err_xfer("rd80_upper", 8'h80, 1'b0, 16'h1234);
    err_xfer("wr54_ro",  8'h54, 1'b1, 16'h1234);

    // Back-to-back: write 0x30, write 0x3C, read 0x30
    setup(8'h30, 1'b1, 32'h0000_1111);
    access();
    @(negedge pclk5);
    chk("b2b_w30_pready", {31'h0, pready5}, 32'h1);
    setup(8'h3C, 1'b1, 32'h0000_2222);
    @(negedge pclk5);
    chk("b2b_m1_sel",   {25'h0, sels},       {25'h0, S_MATCH1});
    chk("b2b_m1_wdata", {16'h0, wdata_out5}, 32'h1111);
    access();
    @(negedge pclk5);
    chk("b2b_w3c_pready", {31'h0, pready5}, 32'h1);
    chk("b2b_gap_sel",  {25'h0, sels},      {25'h0, S_NONE});
    setup(8'h30, 1'b0, 32'h0);
    @(negedge pclk5);
    chk("b2b_m2_sel",   {25'h0, sels},       {25'h0, S_MATCH2});
    chk("b2b_m2_wdata", {16'h0, wdata_out5}, 32'h2222);
    access();
    @(negedge pclk5);
    chk("b2b_r30_wait", {31'h0, pready5}, 32'h0);
    hold();
    @(negedge pclk5);
    chk("b2b_r30_pready", {31'h0, pready5}, 32'h1);
    chk("b2b_r30_prdata", prdata5,          32'h0000_5A5A);
    idle();
    $display("xfer back-to-back w30 w3C r30 data=5a5a");

    // Protocol violation: setup then drop psel, nothing happens
    setup(8'h0C, 1'b1, 32'h0000_007F);
    idle();
    @(negedge pclk5);
    chk("abort_pready", {31'h0, pready5}, 32'h0);
    hold();
    @(negedge pclk5);
    chk("abort_sel",   {25'h0, sels},       {25'h0, S_NONE});
    chk("abort_wdata", {16'h0, wdata_out5}, 32'h2222);
    $display("xfer aborted setup addr=0c");

    // Reset in the access cycle of a write
    setup(8'h00, 1'b1, 32'h0000_0055);
    access();
    #1 n_p_reset5 = 1'b0;
    @(negedge pclk5);
    chk("midrst_pready", {31'h0, pready5},    32'h0);
    chk("midrst_wdata",  {16'h0, wdata_out5}, 32'h0);
    idle();
    n_p_reset5 = 1'b1;
    @(negedge pclk5);
    chk("midrst_sel",  {25'h0, sels}, {25'h0, S_NONE});
    hold();
    @(negedge pclk5);
    chk("midrst_sel2", {25'h0, sels}, {25'h0, S_NONE});
    $display("reset mid-transfer: no strobe");

    // Normal write after reset release
    setup(8'h60, 1'b1, 32'hFFFF_003F);
    access();
    @(negedge pclk5);
    chk("wr60_pready", {31'h0, pready5}, 32'h1);
    idle();
    @(negedge pclk5);
    chk("wr60_sel",   {25'h0, sels},       {25'h0, S_INTR_EN});
    chk("wr60_wdata", {16'h0, wdata_out5}, 32'h003F);
    $display("xfer write addr=60 data=003f");

    hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
